// File: rtl/act_pkg.sv
// Shared types and constants for the activation pipeline.
// Holds the activation-mode encoding, the default widths, and a helper
// that yields the signed saturation bounds for a given output width.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_CLAMP  = 2'b10,
    ACT_LEAKY  = 2'b11
  } act_mode_e;

  localparam int ACT_IN_W        = 32;
  localparam int ACT_OUT_W       = 16;
  localparam int ACT_CHANNELS    = 8;
  localparam int ACT_SHIFT_W     = 5;
  localparam int ACT_CLAMP_MAX   = 1536;
  localparam int ACT_LEAKY_SHIFT = 3;

  // Largest value representable in a w-bit two's-complement word.
  function automatic longint sat_hi(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's-complement word.
  function automatic longint sat_lo(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/act_requant.sv
// Combinational requantiser: rounding arithmetic right shift of a wide
// signed accumulator, then saturation to the signed OUT_W range.
// The shift runs one bit wider than the input so the rounding bias
// can never overflow.
module act_requant
  import act_pkg::*;
#(
  parameter int IN_W    = ACT_IN_W,
  parameter int OUT_W   = ACT_OUT_W,
  parameter int SHIFT_W = ACT_SHIFT_W
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [OUT_W-1:0] v
);

  localparam logic signed [IN_W:0] HI = (IN_W + 1)'(sat_hi(OUT_W));
  localparam logic signed [IN_W:0] LO = (IN_W + 1)'(sat_lo(OUT_W));

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] bias;
  logic signed [IN_W:0] r;

  // Round half up, shift, then clip into the output range.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    xe   = {x[IN_W-1], x};
    bias = '0;
    r    = xe;
    if (shift != '0) begin
      bias = (IN_W + 1)'(1) << (shift - SHIFT_W'(1));
      r    = (xe + bias) >>> shift;
    end
    if (r > HI)      v = HI[OUT_W-1:0];
    else if (r < LO) v = LO[OUT_W-1:0];
    else             v = r[OUT_W-1:0];
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready requantise + activate pipeline.
// Stage 1 registers the requantised, saturated value together with the
// mode it was accepted under; stage 2 registers the activated result.
// Output beats are tagged with a channel index and a last-channel flag.
// Optional feature: define ACT_LEAKY_EN to build the leaky ReLU datapath;
// without it, mode 11 behaves exactly like ReLU.
module activation_pipe
  import act_pkg::*;
#(
  parameter int IN_W        = ACT_IN_W,
  parameter int OUT_W       = ACT_OUT_W,
  parameter int CHANNELS    = ACT_CHANNELS,
  parameter int SHIFT_W     = ACT_SHIFT_W,
  parameter int CLAMP_MAX   = ACT_CLAMP_MAX,
  parameter int LEAKY_SHIFT = ACT_LEAKY_SHIFT,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_mode,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CW-1:0]      out_chan,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [CW-1:0]           LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic signed [OUT_W-1:0] CLAMP_V   = OUT_W'(CLAMP_MAX);

  act_mode_e                mode_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic                     s1_valid;
  logic signed [OUT_W-1:0]  s1_data;
  act_mode_e                s1_mode;
  logic signed [OUT_W-1:0]  rq_v;
  logic signed [OUT_W-1:0]  act_val;
  logic [CW-1:0]            cnt_q;
  logic                     en1;
  logic                     en2;

  // Stage 2 may load when empty or draining; stage 1 when empty or moving on.
  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  act_requant #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .x     ($signed(in_data)),
    .shift (shift_q),
    .v     (rq_v)
  );

  // Configuration registers; a beat accepted together with cfg_we sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      mode_q  <= ACT_RELU;
      shift_q <= '0;
    end else if (cfg_we) begin
      mode_q  <= act_mode_e'(cfg_mode);
      shift_q <= cfg_shift;
    end
  end

  // Stage 1: capture the requantised value and the mode it must be activated with.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too so outputs are defined straight out of reset.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= ACT_RELU;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= rq_v;
        s1_mode <= mode_q;
      end
    end
  end

  // Activation function selected by the mode carried with the beat.
  always_comb begin
    act_val = s1_data;
    case (s1_mode)
      ACT_BYPASS: act_val = s1_data;
      ACT_RELU:   act_val = s1_data[OUT_W-1] ? '0 : s1_data;
      ACT_CLAMP: begin
        if (s1_data[OUT_W-1])     act_val = '0;
        else if (s1_data > CLAMP_V) act_val = CLAMP_V;
        else                        act_val = s1_data;
      end
      ACT_LEAKY: begin
`ifdef ACT_LEAKY_EN
        act_val = s1_data[OUT_W-1] ? (s1_data >>> LEAKY_SHIFT) : s1_data;
`else
        act_val = s1_data[OUT_W-1] ? '0 : s1_data;
`endif
      end
      default: act_val = s1_data;
    endcase
  end

  // Stage 2: registered output beat, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= act_val;
    end
  end

  // Channel counter advances once per delivered beat and wraps after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= (cnt_q == LAST_CHAN) ? '0 : cnt_q + CW'(1);
    end
  end

  assign out_chan = cnt_q;
  assign out_last = (cnt_q == LAST_CHAN);

endmodule
